// File: rtl/buzzer_tone_gen.sv
// Buzzer tone generator: four debounced active-low buttons select a level, apply
// it as a clamped tone half-period, and toggle mute on a square-wave buzzer output.
module buzzer_tone_gen #(
  parameter int LEVEL_W    = 4,
  parameter int CNT_W      = 22,
  parameter int BASE_HALF  = 250000,
  parameter int STEP_HALF  = 15000,
  parameter int MIN_HALF   = 2500,
  parameter int DEB_CYCLES = 1000,
  parameter int WRAP_EN    = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_inc_n_i,
  input  logic               btn_dec_n_i,
  input  logic               btn_freq_n_i,
  input  logic               btn_sil_n_i,
  output logic [LEVEL_W-1:0] led_n_o,
  output logic [CNT_W-1:0]   cmp_o,
  output logic               buzzer_n_o,
  output logic               muted_o
);

  localparam int          NUM_LEVELS = 2 ** LEVEL_W;
  localparam int unsigned NUM_BTN    = 4;
  localparam int unsigned BTN_INC    = 0;
  localparam int unsigned BTN_DEC    = 1;
  localparam int unsigned BTN_FREQ   = 2;
  localparam int unsigned BTN_SIL    = 3;

  localparam int                 DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(NUM_LEVELS - 1);

  localparam int                PROD_W = CNT_W + LEVEL_W + 1;
  localparam logic [PROD_W-1:0] BASE_P = PROD_W'(BASE_HALF);
  localparam logic [PROD_W-1:0] STEP_P = PROD_W'(STEP_HALF);
  localparam logic [PROD_W-1:0] MIN_P  = PROD_W'(MIN_HALF);

  logic [NUM_BTN-1:0] btn_raw;

  logic [NUM_BTN-1:0]            sync1_q, sync1_d;
  logic [NUM_BTN-1:0]            sync2_q, sync2_d;
  logic [NUM_BTN-1:0]            deb_q, deb_d;
  logic [NUM_BTN-1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]            press;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic               tone_ph_q, tone_ph_d;
  logic               muted_q, muted_d;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] diff;
  logic [CNT_W-1:0]  cmp_new;

  assign btn_raw = ~{btn_sil_n_i, btn_freq_n_i, btn_dec_n_i, btn_inc_n_i};

  // A press fires in the same cycle the debounced state rises, so the action
  // lands on the edge that completes the stability window.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    press     = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (press[BTN_INC] && !press[BTN_DEC]) begin
      if (level_q == LVL_MAX) begin
        level_d = (WRAP_EN != 0) ? '0 : level_q;
      end else begin
        level_d = level_q + LEVEL_W'(1);
      end
    end else if (press[BTN_DEC] && !press[BTN_INC]) begin
      if (level_q == '0) begin
        level_d = (WRAP_EN != 0) ? LVL_MAX : level_q;
      end else begin
        level_d = level_q - LEVEL_W'(1);
      end
    end
  end

  // Wide arithmetic keeps the subtraction from wrapping before the floor clamp.
  always_comb begin
    prod = PROD_W'(level_q) * STEP_P;
    if (prod >= BASE_P) begin
      diff = '0;
    end else begin
      diff = BASE_P - prod;
    end
    if (diff < MIN_P) begin
      cmp_new = CNT_W'(MIN_HALF);
    end else begin
      cmp_new = CNT_W'(diff);
    end
    cmp_d = press[BTN_FREQ] ? cmp_new : cmp_q;
  end

  always_comb begin
    tone_cnt_d = tone_cnt_q + CNT_W'(1);
    tone_ph_d  = tone_ph_q;
    if (press[BTN_FREQ]) begin
      tone_cnt_d = '0;
      tone_ph_d  = 1'b0;
    end else if (tone_cnt_q == cmp_q - CNT_W'(1)) begin
      tone_cnt_d = '0;
      tone_ph_d  = ~tone_ph_q;
    end
    muted_d = muted_q ^ press[BTN_SIL];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_cnt_q  <= '0;
      level_q    <= '0;
      cmp_q      <= CNT_W'(BASE_HALF);
      tone_cnt_q <= '0;
      tone_ph_q  <= 1'b0;
      muted_q    <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      cmp_q      <= cmp_d;
      tone_cnt_q <= tone_cnt_d;
      tone_ph_q  <= tone_ph_d;
      muted_q    <= muted_d;
    end
  end

  assign led_n_o    = ~level_q;
  assign cmp_o      = cmp_q;
  assign muted_o    = muted_q;
  assign buzzer_n_o = muted_q | ~tone_ph_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen: saturating instance plus a wrap-around
// instance sharing the same buttons, small parameters for short latencies.
module tb_buzzer_tone_gen;

  logic clk;
  logic rst;
  logic inc_n, dec_n, freq_n, sil_n;

  logic [1:0]  led0, led1;
  logic [21:0] cmp0, cmp1;
  logic        buz0, buz1;
  logic        mut0, mut1;

  int n_checks = 0;
  int n_errors = 0;

  buzzer_tone_gen #(
    .LEVEL_W(2), .CNT_W(22), .BASE_HALF(10), .STEP_HALF(3),
    .MIN_HALF(4), .DEB_CYCLES(4), .WRAP_EN(0)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .btn_inc_n_i(inc_n), .btn_dec_n_i(dec_n),
    .btn_freq_n_i(freq_n), .btn_sil_n_i(sil_n),
    .led_n_o(led0), .cmp_o(cmp0), .buzzer_n_o(buz0), .muted_o(mut0)
  );

  buzzer_tone_gen #(
    .LEVEL_W(2), .CNT_W(22), .BASE_HALF(10), .STEP_HALF(3),
    .MIN_HALF(4), .DEB_CYCLES(4), .WRAP_EN(1)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .btn_inc_n_i(inc_n), .btn_dec_n_i(dec_n),
    .btn_freq_n_i(freq_n), .btn_sil_n_i(sil_n),
    .led_n_o(led1), .cmp_o(cmp1), .buzzer_n_o(buz1), .muted_o(mut1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       inc_n  = v;
      1:       dec_n  = v;
      2:       freq_n = v;
      default: sil_n  = v;
    endcase
  endtask

  task automatic press(input int idx, input int hold);
    set_btn(idx, 1'b0);
    repeat (hold) @(negedge clk);
    set_btn(idx, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  // Waits for a buzzer edge, then counts cycles to the next one (-1 on timeout).
  task automatic measure(output int len);
    logic b;
    int   n;
    len = -1;
    b = buz0;
    n = 0;
    while (buz0 === b && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (buz0 === b) return;
    b = buz0;
    n = 0;
    while (buz0 === b && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (buz0 !== b) len = n;
  endtask

  initial begin
    int len;
    int bad;
    rst = 1'b1;
    inc_n = 1'b1; dec_n = 1'b1; freq_n = 1'b1; sil_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_led",   led0, 2'b11);
    check("rst_cmp",   cmp0, 10);
    check("rst_muted", mut0, 1);
    check("rst_buz",   buz0, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unmute: tone runs at half-period 10 from reset
    press(3, 5);
    check("unmute", mut0, 0);
    measure(len);
    check("half_base_a", len, 10);
    measure(len);
    check("half_base_b", len, 10);
    press(3, 5);
    check("remute", mut0, 1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (buz0 !== 1'b1) bad++;
    end
    check("muted_quiet", bad, 0);

    // Press latency: action on edge 6 with DEB_CYCLES=4
    inc_n = 1'b0;
    repeat (5) @(negedge clk);
    check("inc_lat_pre", led0, 2'b11);
    @(negedge clk);
    check("inc_lat", led0, 2'b10);
    inc_n = 1'b1;
    repeat (12) @(negedge clk);
    press(0, 5);
    check("lvl2_led", led0, 2'b01);
    check("cmp_pre_freq", cmp0, 10);
    press(2, 5);
    check("freq_lvl2", cmp0, 4);
    check("freq_lvl2_wrap", cmp1, 4);

    // Short glitch, saturation and wrap
    press(0, 3);
    check("glitch", led0, 2'b01);
    press(0, 5);
    check("lvl3_sat", led0, 2'b00);
    check("lvl3_wrap", led1, 2'b00);
    for (int i = 0; i < 5; i++) press(0, 5);
    check("inc_hold", led0, 2'b00);
    check("inc_wrap", led1, 2'b11);

    // Floor clamp at level 3; wrap instance sits at level 0
    press(2, 5);
    check("freq_floor", cmp0, 4);
    check("freq_wrap_l0", cmp1, 10);
    press(3, 5);
    check("unmute2", mut0, 0);
    measure(len);
    check("half_floor_a", len, 4);
    measure(len);
    check("half_floor_b", len, 4);

    // Decrement to floor and beyond
    for (int i = 0; i < 4; i++) press(1, 5);
    check("dec_hold", led0, 2'b11);
    check("dec_wrap", led1, 2'b11);
    press(0, 5);
    check("lvl1_led", led0, 2'b10);

    // Simultaneous inc, dec and freq at level 1
    inc_n = 1'b0; dec_n = 1'b0; freq_n = 1'b0;
    repeat (5) @(negedge clk);
    check("combo_pre_cmp", cmp0, 4);
    @(negedge clk);
    check("combo_led", led0, 2'b10);
    check("combo_cmp", cmp0, 7);
    check("combo_cmp_wrap", cmp1, 7);
    check("combo_buz", buz0, 1);
    len = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (buz0 !== 1'b1) begin
        len = n;
        break;
      end
    end
    check("combo_clear", len, 7);
    inc_n = 1'b1; dec_n = 1'b1; freq_n = 1'b1;
    repeat (12) @(negedge clk);
    measure(len);
    check("half_combo", len, 7);

    // Reset mid-debounce at level 2, unmuted
    press(0, 5);
    check("pre_rst_led", led0, 2'b01);
    inc_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_led",   led0, 2'b11);
    check("rst2_cmp",   cmp0, 10);
    check("rst2_muted", mut0, 1);
    check("rst2_buz",   buz0, 1);
    check("rst2_wrap",  led1, 2'b11);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_pre", led0, 2'b11);
    @(negedge clk);
    check("post_rst_lat", led0, 2'b10);
    inc_n = 1'b1;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
